// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the mm:ss stopwatch sequencer.
package stopwatch_pkg;

  // Mode FSM states
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    PAUSED = 2'd1,
    ADJUST = 2'd2
  } state_e;

  // First anode lit out of reset (active low)
  localparam logic [3:0] AN_RESET     = 4'b1110;

  // BCD limits; minutes and seconds share the same 00..59 range
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;
  localparam logic [3:0] ONES_MAX     = 4'd9;

  // Two-digit BCD field (tens:ones)
  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd2_t;

  localparam bcd2_t BCD2_ZERO = '0;

  // True when the field reads 59 and the next increment wraps
  function automatic logic bcd2_at_max(input bcd2_t v);
    return (v.tens == SEC_TENS_MAX) && (v.ones == ONES_MAX);
  endfunction

  // 00..59 BCD increment with wrap to 00
  function automatic bcd2_t bcd2_inc(input bcd2_t v);
    bcd2_t r;
    r = v;
    if (v.ones == ONES_MAX) begin
      r.ones = 4'd0;
      r.tens = (v.tens == SEC_TENS_MAX) ? 4'd0 : v.tens + 4'd1;
    end else begin
      r.ones = v.ones + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_btn_debounce.sv
// Button conditioner: 2-FF synchronizer, stability counter and a
// one-cycle pulse on each accepted press (0->1 of the stable level).
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic pulse_o
);

  localparam int            CW       = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic [1:0]    sync_q;
  logic          smp;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pulse_q, pulse_d;

  assign smp = sync_q[1];

  // Count consecutive samples that disagree with the stable level; the
  // DEBOUNCE_CYC-th one in a row flips the level. Any agreeing sample
  // restarts the count, so bounces never accumulate.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    pulse_d  = 1'b0;
    if (smp != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = smp;
        pulse_d  = smp;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Synchronizer and debounce state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= 2'b00;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      pulse_q  <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], btn_i};
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      pulse_q  <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// mm:ss stopwatch sequencer: button conditioning, RUN/PAUSED/ADJUST mode
// FSM, BCD minute/second counters, anode scan and adjust blink phase.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ       = 100_000_000,
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int ADJ_HZ       = 2,
  parameter int SCAN_HZ      = 500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_pause,
  input  logic       btn_reset,
  input  logic       sw_adj,
  input  logic       sw_sel,
  output logic [3:0] an,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       adj,
  output logic       sel,
  output logic       blink
);

  localparam int ADJ_DIV  = CLK_HZ / ADJ_HZ;
  localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
  localparam int P1_W     = $clog2(CLK_HZ + 1);
  localparam int ADJ_W    = $clog2(ADJ_DIV + 1);
  localparam int SCAN_W   = $clog2(SCAN_DIV + 1);

  localparam logic [P1_W-1:0]   P1_LAST   = P1_W'(CLK_HZ - 1);
  localparam logic [ADJ_W-1:0]  ADJ_LAST  = ADJ_W'(ADJ_DIV - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  // ---------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------
  logic       pause_pulse;
  logic       clr_pulse;
  logic [1:0] adj_sync_q;
  logic [1:0] sel_sync_q;
  logic       adj_s;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_pause_db (
    .clk     (clk),
    .rst     (rst),
    .btn_i   (btn_pause),
    .pulse_o (pause_pulse)
  );

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_reset_db (
    .clk     (clk),
    .rst     (rst),
    .btn_i   (btn_reset),
    .pulse_o (clr_pulse)
  );

  // Switches are level controls; synchronize only, no debounce
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      adj_sync_q <= 2'b00;
      sel_sync_q <= 2'b00;
    end else begin
      adj_sync_q <= {adj_sync_q[0], sw_adj};
      sel_sync_q <= {sel_sync_q[0], sw_sel};
    end
  end

  assign adj_s = adj_sync_q[1];
  assign sel   = sel_sync_q[1];

  // ---------------------------------------------------------------------
  // Tick generation
  // ---------------------------------------------------------------------
  state_e              state_q;
  state_e              ret_q;
  logic                adj_q;
  logic                blink_q;
  logic [P1_W-1:0]     p1_q, p1_d;
  logic [ADJ_W-1:0]    adj_cnt_q, adj_cnt_d;
  logic [SCAN_W-1:0]   scan_cnt_q, scan_cnt_d;
  logic                tick_1hz;
  logic                tick_adj;
  logic                tick_scan;

  // The 1 Hz tick only exists in RUN; the prescaler is frozen elsewhere
  assign tick_1hz  = (state_q == RUN) && (p1_q == P1_LAST);
  assign tick_adj  = (adj_cnt_q == ADJ_LAST);
  assign tick_scan = (scan_cnt_q == SCAN_LAST);

  // 1 Hz prescaler: counts in RUN, holds in PAUSED (resume mid-period),
  // pinned at 0 in ADJUST so leaving ADJUST starts a full second.
  always_comb begin
    p1_d = p1_q;
    if (clr_pulse || state_q == ADJUST) begin
      p1_d = '0;
    end else if (state_q == RUN) begin
      p1_d = tick_1hz ? '0 : p1_q + P1_W'(1);
    end
  end

  // Free-running dividers for adjust rate and anode scan
  always_comb begin
    adj_cnt_d  = tick_adj  ? '0 : adj_cnt_q  + ADJ_W'(1);
    scan_cnt_d = tick_scan ? '0 : scan_cnt_q + SCAN_W'(1);
  end

  // Prescaler and divider registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p1_q       <= '0;
      adj_cnt_q  <= '0;
      scan_cnt_q <= '0;
    end else begin
      p1_q       <= p1_d;
      adj_cnt_q  <= adj_cnt_d;
      scan_cnt_q <= scan_cnt_d;
    end
  end

  // ---------------------------------------------------------------------
  // Mode FSM with registered adj/blink. sw_adj is checked before the
  // pause pulse so a coincident pause is dropped and ret_q keeps the
  // state as it was before that pause.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      ret_q   <= RUN;
      adj_q   <= 1'b0;
      blink_q <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (adj_s) begin
            state_q <= ADJUST;
            ret_q   <= RUN;
            adj_q   <= 1'b1;
          end else if (pause_pulse) begin
            state_q <= PAUSED;
          end
        end
        PAUSED: begin
          if (adj_s) begin
            state_q <= ADJUST;
            ret_q   <= PAUSED;
            adj_q   <= 1'b1;
          end else if (pause_pulse) begin
            state_q <= RUN;
          end
        end
        ADJUST: begin
          if (!adj_s) begin
            state_q <= ret_q;
            adj_q   <= 1'b0;
            blink_q <= 1'b0;
          end else if (tick_adj) begin
            blink_q <= ~blink_q;
          end
        end
        default: begin
          state_q <= RUN;
          adj_q   <= 1'b0;
          blink_q <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // BCD time counters
  // ---------------------------------------------------------------------
  bcd2_t sec_q, sec_d;
  bcd2_t min_q, min_d;

  // Clear pulse beats any tick. RUN carries seconds into minutes; ADJUST
  // bumps only the selected field, with no carry between fields.
  always_comb begin
    sec_d = sec_q;
    min_d = min_q;
    if (clr_pulse) begin
      sec_d = BCD2_ZERO;
      min_d = BCD2_ZERO;
    end else if (tick_1hz) begin
      sec_d = bcd2_inc(sec_q);
      if (bcd2_at_max(sec_q)) min_d = bcd2_inc(min_q);
    end else if (state_q == ADJUST && tick_adj) begin
      if (sel) sec_d = bcd2_inc(sec_q);
      else     min_d = bcd2_inc(min_q);
    end
  end

  // Digit registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sec_q <= BCD2_ZERO;
      min_q <= BCD2_ZERO;
    end else begin
      sec_q <= sec_d;
      min_q <= min_d;
    end
  end

  // ---------------------------------------------------------------------
  // Anode scan: rotate the single low bit toward the MSB
  // ---------------------------------------------------------------------
  logic [3:0] an_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            an_q <= AN_RESET;
    else if (tick_scan) an_q <= {an_q[2:0], an_q[3]};
  end

  assign an       = an_q;
  assign sec_ones = sec_q.ones;
  assign sec_tens = sec_q.tens;
  assign min_ones = min_q.ones;
  assign min_tens = min_q.tens;
  assign adj      = adj_q;
  assign blink    = blink_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl at reduced clock rates.
module tb_stopwatch_ctrl;
  import stopwatch_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_pause = 1'b0;
  logic       btn_reset = 1'b0;
  logic       sw_adj = 1'b0;
  logic       sw_sel = 1'b0;
  logic [3:0] an, sec_ones, sec_tens, min_ones, min_tens;
  logic       adj, sel, blink;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  int pcount  = 0;
  int pcyc    = 0;

  stopwatch_ctrl #(
    .CLK_HZ(100), .DEBOUNCE_CYC(4), .ADJ_HZ(4), .SCAN_HZ(20)
  ) dut (
    .clk(clk), .rst(rst), .btn_pause(btn_pause), .btn_reset(btn_reset),
    .sw_adj(sw_adj), .sw_sel(sw_sel), .an(an),
    .sec_ones(sec_ones), .sec_tens(sec_tens),
    .min_ones(min_ones), .min_tens(min_tens),
    .adj(adj), .sel(sel), .blink(blink)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every accepted pause press and the cycle it appeared in
  always @(negedge clk) begin
    if (dut.u_pause_db.pulse_o === 1'b1) begin
      pcount <= pcount + 1;
      pcyc   <= cyc;
    end
  end

  function automatic int mm();
    return int'(min_tens) * 10 + int'(min_ones);
  endfunction

  function automatic int ss();
    return int'(sec_tens) * 10 + int'(sec_ones);
  endfunction

  function automatic logic [15:0] digits();
    return {min_tens, min_ones, sec_tens, sec_ones};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_time(input int m, input int s, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (mm() == m && ss() == s) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  // Returns at the first negedge after blink toggles (just after a tick_adj)
  task automatic wait_blink(output bit ok);
    logic b;
    b  = blink;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (blink !== b) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  // Dial in mm:ss through ADJUST; field switches happen just after a tick
  task automatic set_time(input int m, input int s, output bit ok);
    bit t;
    ok = 1'b0;
    sw_sel = 1'b0;
    tick(3);
    sw_adj = 1'b1;
    wait_blink(t);
    if (!t) return;
    for (int i = 0; i < 61 && mm() != m; i++) begin
      wait_blink(t);
      if (!t) return;
    end
    if (mm() != m) return;
    sw_sel = 1'b1;
    for (int i = 0; i < 61 && ss() != s; i++) begin
      wait_blink(t);
      if (!t) return;
    end
    if (ss() != s) return;
    sw_adj = 1'b0;
    ok = 1'b1;
  endtask

  task automatic press_pause();
    btn_pause = 1'b1;
    tick(10);
    btn_pause = 1'b0;
    tick(10);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    vectors++;
    if (digits() !== 16'h0000) begin
      errors++; $display("FAIL reset_digits: got %h want 0000", digits());
    end
    vectors++;
    if (an !== 4'b1110) begin
      errors++; $display("FAIL reset_an: got %b want 1110", an);
    end
    vectors++;
    if ({adj, sel, blink} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b want 000", {adj, sel, blink});
    end
  endtask

  task automatic test_run_wrap();
    bit ok;
    rst = 1'b0;
    tick(6000);
    vectors++;
    if (digits() !== 16'h0100) begin
      errors++; $display("FAIL run_6000: got %h want 0100", digits());
    end
    set_time(59, 59, ok);
    vectors++;
    if (!ok || digits() !== 16'h5959) begin
      errors++; $display("FAIL preload_5959: got %h ok=%0d want 5959", digits(), ok);
    end
    tick(50);
    vectors++;
    if (digits() !== 16'h5959) begin
      errors++; $display("FAIL exit_prescaler_clear: got %h want 5959", digits());
    end
    tick(55);
    vectors++;
    if (digits() !== 16'h0000) begin
      errors++; $display("FAIL wrap_5959: got %h want 0000", digits());
    end
  endtask

  task automatic test_pause();
    bit ok;
    int bad;
    wait_time(0, 3, 500, ok);
    vectors++;
    if (!ok) begin
      errors++; $display("FAIL reach_0003: got %h want 0003", digits());
    end
    btn_pause = 1'b1;
    tick(10);
    btn_pause = 1'b0;
    bad = 0;
    for (int i = 0; i < 500; i++) begin
      tick(1);
      if (digits() !== 16'h0003) bad++;
    end
    vectors++;
    if (bad != 0) begin
      errors++; $display("FAIL pause_hold: %0d cycles off 0003, want 0", bad);
    end
    // Resume: tick lands 100 cycles after press, not a full period later
    btn_pause = 1'b1;
    tick(10);
    btn_pause = 1'b0;
    tick(85);
    vectors++;
    if (digits() !== 16'h0003) begin
      errors++; $display("FAIL resume_early: got %h want 0003", digits());
    end
    tick(8);
    vectors++;
    if (digits() !== 16'h0004) begin
      errors++; $display("FAIL resume_midperiod: got %h want 0004", digits());
    end
  endtask

  task automatic test_bounce();
    int n0, rise;
    n0 = pcount;
    btn_pause = 1'b1;
    tick(2);
    btn_pause = 1'b0;
    tick(2);
    btn_pause = 1'b1;
    rise = cyc;
    tick(12);
    btn_pause = 1'b0;
    tick(10);
    vectors++;
    if (pcount - n0 != 1) begin
      errors++; $display("FAIL bounce_count: got %0d pulses want 1", pcount - n0);
    end
    vectors++;
    if (pcyc - rise != 6) begin
      errors++; $display("FAIL bounce_latency: got %0d want 6", pcyc - rise);
    end
  endtask

  task automatic test_adjust_sec();
    bit t;
    logic b0;
    sw_sel = 1'b1;
    tick(3);
    sw_adj = 1'b1;
    tick(4);
    vectors++;
    if (adj !== 1'b1) begin
      errors++; $display("FAIL adj_flag: got %b want 1", adj);
    end
    wait_blink(t);
    for (int i = 0; i < 61 && t && ss() != 58; i++) wait_blink(t);
    vectors++;
    if (!t || digits() !== 16'h0058) begin
      errors++; $display("FAIL adj_reach_0058: got %h want 0058", digits());
    end
    b0 = blink;
    tick(25);
    vectors++;
    if (digits() !== 16'h0059 || blink !== ~b0) begin
      errors++; $display("FAIL adj_tick1: got %h blink %b want 0059 blink %b", digits(), blink, ~b0);
    end
    tick(25);
    vectors++;
    if (digits() !== 16'h0000 || blink !== b0) begin
      errors++; $display("FAIL adj_sec_wrap: got %h blink %b want 0000 blink %b", digits(), blink, b0);
    end
    sw_adj = 1'b0;
    tick(5);
    vectors++;
    if ({adj, blink} !== 2'b00) begin
      errors++; $display("FAIL adj_exit_flags: got %b want 00", {adj, blink});
    end
    // Entered from PAUSED, so it must return to PAUSED and hold
    tick(150);
    vectors++;
    if (digits() !== 16'h0000) begin
      errors++; $display("FAIL adj_ret_paused: got %h want 0000", digits());
    end
  endtask

  task automatic test_clear_vs_tick();
    bit ok;
    press_pause();
    set_time(12, 33, ok);
    wait_time(12, 34, 130, ok);
    vectors++;
    if (!ok) begin
      errors++; $display("FAIL reach_1234: got %h want 1234", digits());
    end
    tick(93);
    btn_reset = 1'b1;
    tick(6);
    vectors++;
    if ({dut.tick_1hz, dut.clr_pulse} !== 2'b11 || digits() !== 16'h1234) begin
      errors++; $display("FAIL clr_align: tick/clr %b digits %h want 11 1234",
                         {dut.tick_1hz, dut.clr_pulse}, digits());
    end
    tick(1);
    vectors++;
    if (digits() !== 16'h0000) begin
      errors++; $display("FAIL clr_wins: got %h want 0000", digits());
    end
    vectors++;
    if (dut.state_q !== RUN) begin
      errors++; $display("FAIL clr_state: got %0d want %0d", dut.state_q, RUN);
    end
    btn_reset = 1'b0;
    tick(10);
  endtask

  task automatic test_async_reset();
    bit ok;
    logic [3:0] seq [0:3];
    seq[0] = 4'b1110; seq[1] = 4'b1101; seq[2] = 4'b1011; seq[3] = 4'b0111;
    set_time(7, 20, ok);
    wait_time(7, 21, 130, ok);
    ok = ok && 1'b0;
    for (int i = 0; i < 25; i++) begin
      if (an === 4'b1011 && digits() === 16'h0721) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
    vectors++;
    if (!ok) begin
      errors++; $display("FAIL reach_0721_an1011: got %h an %b", digits(), an);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (digits() !== 16'h0000 || an !== 4'b1110 || {adj, blink} !== 2'b00) begin
      errors++; $display("FAIL async_rst: got %h an %b adj/blink %b want 0000 1110 00",
                         digits(), an, {adj, blink});
    end
    vectors++;
    if (dut.state_q !== RUN) begin
      errors++; $display("FAIL async_rst_state: got %0d want %0d", dut.state_q, RUN);
    end
    tick(2);
    rst = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      vectors++;
      if (an !== seq[(k / 5) % 4]) begin
        errors++; $display("FAIL scan_k%0d: got %b want %b", k, an, seq[(k / 5) % 4]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_run_wrap();
    test_pause();
    test_bounce();
    test_adjust_sec();
    test_clear_vs_tick();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
